// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan-out path.
//   - Nominal 640x480@60 totals and NES source geometry.
//   - rgb9_t: packed {r,g,b}, 3 bits each, same layout as vga_fb rgb.
//   - h_region_t: scan region within a line or a frame.
//   - region_of(): maps a counter value to its region from the boundaries.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int NES_W   = 256;
  localparam int NES_H   = 240;
  localparam int SCALE   = 2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb9_t;

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } h_region_t;

  // Boundaries are the first count of each region after ACTIVE.
  function automatic h_region_t region_of(input logic [9:0] cnt,
                                          input logic [9:0] fp_start,
                                          input logic [9:0] sync_start,
                                          input logic [9:0] bp_start);
    h_region_t reg_v;
    if (cnt < fp_start) begin
      reg_v = ACTIVE;
    end else if (cnt < sync_start) begin
      reg_v = FP;
    end else if (cnt < bp_start) begin
      reg_v = SYNC;
    end else begin
      reg_v = BP;
    end
    return reg_v;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register used to align timing/control bits with the
// framebuffer read latency. All stages clear to zero on reset.
//   clk    in           clock
//   rst_n  in           async active-low reset
//   i_d    in  [WIDTH]  data entering stage 0
//   o_q    out [WIDTH]  data after DEPTH clocks (DEPTH must be >= 1)
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] r_q;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          r_q <= i_d;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          r_q <= g_stage[gi-1].r_q;
        end
      end
    end
  end

  assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/vga_scan.sv
// ---------------------------------------------------------------------------
// vga_scan
// 640x480@60 VGA timing generator and read-side driver of the NES
// framebuffer. The 256x240 image is doubled to 512x480 and placed at
// h_cnt = X_OFFSET. Pointers go to vga_fb combinationally; the returned
// colour and the sync/window bits are aligned so every pin lags the
// counters by FB_LATENCY+1 clocks.
//
// Optional build macro: TEST_PATTERN_EN -- when defined, test_mode = 1
// replaces the picture with 8 vertical colour bars; when undefined,
// test_mode is ignored.
//
// Ports:
//   pix_clk      in       pixel clock
//   rst_n        in       async active-low reset
//   pix_ptr_x    out [8]  framebuffer column
//   pix_ptr_y    out [8]  framebuffer row
//   fb_rgb       in  [9]  {r,g,b} from vga_fb, FB_LATENCY after the pointer
//   test_mode    in       colour-bar select
//   vga_r/g/b    out [3]  colour pins, black outside the NES window
//   vga_hs/vs    out      syncs, active low
//   vblank       out      v_cnt >= V_ACTIVE, not delayed
//   frame_start  out      one-cycle pulse at (0,0), not delayed; suppressed
//                         at the (0,0) seen straight out of reset
// ---------------------------------------------------------------------------
module vga_scan
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int X_OFFSET   = 64,
  parameter int FB_LATENCY = 1
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  logic [8:0] fb_rgb,
  input  logic       test_mode,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vblank,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_M1     = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_M1    = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_BP_M1      = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_LO         = 10'(X_OFFSET);
  localparam logic [9:0] X_HI         = 10'(X_OFFSET + NES_W * SCALE);

  // ---------------------------------------------------------------- counters
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_wrapped;   // set once a full frame has elapsed since reset
  logic       w_h_last;
  logic       w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_wrapped <= 1'b0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      if (w_v_last) begin
        r_v_cnt   <= '0;
        r_wrapped <= 1'b1;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // ------------------------------------------------- horizontal region FSM
  // The state always names the region of the current h_cnt, so it changes
  // on the edge where h_cnt enters the next region.
  h_region_t r_h_state;
  h_region_t w_h_state_next;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_state <= ACTIVE;
    end else begin
      r_h_state <= w_h_state_next;
    end
  end

  always_comb begin
    w_h_state_next = r_h_state;
    case (r_h_state)
      ACTIVE:  if (r_h_cnt == H_ACT_M1)  w_h_state_next = FP;
      FP:      if (r_h_cnt == H_SYNC_M1) w_h_state_next = SYNC;
      SYNC:    if (r_h_cnt == H_BP_M1)   w_h_state_next = BP;
      BP:      if (w_h_last)             w_h_state_next = ACTIVE;
      default:                           w_h_state_next = ACTIVE;
    endcase
  end

  // ------------------------------------------------------ vertical decode
  h_region_t w_v_region;
  assign w_v_region = region_of(r_v_cnt, V_FP_START, V_SYNC_START, V_BP_START);

  assign vblank      = (w_v_region != ACTIVE);
  assign frame_start = r_wrapped && (r_h_cnt == '0) && (r_v_cnt == '0);

  // Syncs travel active-high so that cleared pipeline stages mean "idle".
  logic w_hs_act;
  logic w_vs_act;
  assign w_hs_act = (r_h_state == SYNC);
  assign w_vs_act = (w_v_region == SYNC);

  // ------------------------------------------------- window and pointers
  logic       w_win;
  logic [7:0] w_ptr_x;
  logic [7:0] w_ptr_y;

  assign w_win   = (r_h_cnt >= X_LO) && (r_h_cnt < X_HI) && (r_v_cnt < V_FP_START);
  assign w_ptr_x = w_win ? 8'((r_h_cnt - X_LO) >> 1) : 8'd0;
  assign w_ptr_y = w_win ? 8'(r_v_cnt >> 1) : 8'd0;

  assign pix_ptr_x = w_ptr_x;
  assign pix_ptr_y = w_ptr_y;

  // --------------------------------------------------- alignment pipeline
  logic w_win_d;
  logic w_hs_act_d;
  logic w_vs_act_d;

`ifdef TEST_PATTERN_EN
  localparam int PIPE_W = 6;
  logic [2:0] w_bar_d;
`else
  localparam int PIPE_W = 3;
`endif

  logic [PIPE_W-1:0] w_pipe_in;
  logic [PIPE_W-1:0] w_pipe_out;

`ifdef TEST_PATTERN_EN
  assign w_pipe_in = {w_ptr_x[7:5], w_win, w_vs_act, w_hs_act};
  assign {w_bar_d, w_win_d, w_vs_act_d, w_hs_act_d} = w_pipe_out;
`else
  assign w_pipe_in = {w_win, w_vs_act, w_hs_act};
  assign {w_win_d, w_vs_act_d, w_hs_act_d} = w_pipe_out;
`endif

  vga_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (FB_LATENCY)
  ) u_align (
    .clk   (pix_clk),
    .rst_n (rst_n),
    .i_d   (w_pipe_in),
    .o_q   (w_pipe_out)
  );

  // ------------------------------------------------------ colour select
  rgb9_t w_fb;
  rgb9_t w_rgb_sel;
  assign w_fb = fb_rgb;

`ifdef TEST_PATTERN_EN
  always_comb begin
    w_rgb_sel = w_fb;
    if (test_mode) begin
      w_rgb_sel.r = {3{w_bar_d[2]}};
      w_rgb_sel.g = {3{w_bar_d[1]}};
      w_rgb_sel.b = {3{w_bar_d[0]}};
    end
  end
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_rgb_sel = w_fb;
`endif

  // ------------------------------------------------------ output register
  // Gating on the delayed window keeps undefined fb data off the pins.
  rgb9_t r_rgb;
  logic  r_hs;
  logic  r_vs;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_win_d ? w_rgb_sel : '0;
      r_hs  <= ~w_hs_act_d;
      r_vs  <= ~w_vs_act_d;
    end
  end

  assign vga_r  = r_rgb.r;
  assign vga_g  = r_rgb.g;
  assign vga_b  = r_rgb.b;
  assign vga_hs = r_hs;
  assign vga_vs = r_vs;

endmodule

// File: tb/tb_vga_scan.sv
// ---------------------------------------------------------------------------
// tb_vga_scan
// Horizontal timing is the nominal 800-clock line; the vertical timing is
// shortened (24 active, 3 FP, 2 sync, 3 BP = 32 lines, 25600 clocks/frame)
// to keep whole-frame sequences short. cyc counts rising edges since the
// last reset release, so counters sit at h = cyc % 800, v = cyc / 800 and
// the pins show the counters of cyc-2. A model framebuffer returns
// {ptr_x[2:0], ptr_y[2:0], 3'b101} one clock after the pointer.
// ---------------------------------------------------------------------------
module tb_vga_scan;

  localparam int TB_VA = 24;
  localparam int TB_VFP = 3;
  localparam int TB_VSYNC = 2;
  localparam int TB_VBP = 3;

  logic       pix_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_mode = 1'b0;
  logic [7:0] pix_ptr_x;
  logic [7:0] pix_ptr_y;
  logic [8:0] fb_rgb;
  logic [2:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vblank, frame_start;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 pix_clk = ~pix_clk;

  always @(posedge pix_clk) fb_rgb <= {pix_ptr_x[2:0], pix_ptr_y[2:0], 3'b101};

  vga_scan #(
    .V_ACTIVE (TB_VA),
    .V_FP     (TB_VFP),
    .V_SYNC   (TB_VSYNC),
    .V_BP     (TB_VBP)
  ) dut (
    .pix_clk     (pix_clk),
    .rst_n       (rst_n),
    .pix_ptr_x   (pix_ptr_x),
    .pix_ptr_y   (pix_ptr_y),
    .fb_rgb      (fb_rgb),
    .test_mode   (test_mode),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  typedef struct {
    int         t;
    logic [7:0] px;
    logic [7:0] py;
    logic [2:0] r, g, b;
    logic       hs, vs, vb, fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int t, input int px, input int py, input int r, input int g,
                     input int b, input int hs, input int vs, input int vb, input int fs);
    vec_t v;
    v.t  = t;
    v.px = 8'(px);
    v.py = 8'(py);
    v.r  = 3'(r);
    v.g  = 3'(g);
    v.b  = 3'(b);
    v.hs = 1'(hs);
    v.vs = 1'(vs);
    v.vb = 1'(vb);
    v.fs = 1'(fs);
    tbl.push_back(v);
  endtask

  // {px, py, r, g, b, hs, vs, vblank, frame_start}
  function automatic logic [31:0] obs();
    return 32'({pix_ptr_x, pix_ptr_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start});
  endfunction

  function automatic logic [31:0] pack(input vec_t v);
    return 32'({v.px, v.py, v.r, v.g, v.b, v.hs, v.vs, v.vb, v.fs});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge pix_clk);
    cyc++;
    @(negedge pix_clk);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  localparam logic [31:0] RESET_VEC = 32'({8'd0, 8'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});

  initial begin
    int   hs_low, vs_low, vb_hi, fs_cnt;
    int   hs_fall1, hs_fall2, hs_rise1, vs_fall, vb_rise, vb_fall, fs_at;
    logic prev_hs, prev_vs, prev_vb;
    vec_t e;

    // ------------------------------------------------ reset held 5 cycles
    repeat (5) @(negedge pix_clk);
    chk("reset_hold", obs(), RESET_VEC);

    //   t      px   py   r  g  b  hs vs vb fs
    add(0,      0,   0,   0, 0, 0, 1, 1, 0, 0);  // (0,0) out of reset: no frame_start
    add(2401,   0,   0,   0, 0, 0, 1, 1, 0, 0);  // v3 h1
    add(2463,   0,   0,   0, 0, 0, 1, 1, 0, 0);  // h63 just left of window
    add(2464,   0,   1,   0, 0, 0, 1, 1, 0, 0);  // h64 first window column
    add(2465,   0,   1,   0, 0, 0, 1, 1, 0, 0);  // h65 still column 0
    add(2466,   1,   1,   0, 1, 5, 1, 1, 0, 0);  // pins show h64: x0 y1
    add(2467,   1,   1,   0, 1, 5, 1, 1, 0, 0);  // pins show h65
    add(2468,   2,   1,   1, 1, 5, 1, 1, 0, 0);  // pins show h66: x1
    add(2480,   8,   1,   7, 1, 5, 1, 1, 0, 0);  // pins show h78: x7
    add(2975, 255,   1,   6, 1, 5, 1, 1, 0, 0);  // h575 last column; pins x254
    add(2976,   0,   0,   7, 1, 5, 1, 1, 0, 0);  // h576 outside; pins x255
    add(2977,   0,   0,   7, 1, 5, 1, 1, 0, 0);  // pins show h575
    add(2978,   0,   0,   0, 0, 0, 1, 1, 0, 0);  // pins show h576: black
    add(3057,   0,   0,   0, 0, 0, 1, 1, 0, 0);  // pins h655
    add(3058,   0,   0,   0, 0, 0, 0, 1, 0, 0);  // pins h656: hsync starts
    add(3153,   0,   0,   0, 0, 0, 0, 1, 0, 0);  // pins h751: last sync clock
    add(3154,   0,   0,   0, 0, 0, 1, 1, 0, 0);  // pins h752
    add(18500, 18,  11,   1, 3, 5, 1, 1, 0, 0);  // v23 h100 last visible line
    add(19200,  0,   0,   0, 0, 0, 1, 1, 1, 0);  // v24 h0: vblank rises
    add(19300,  0,   0,   0, 0, 0, 1, 1, 1, 0);  // v24 h100: black
    add(20658,  0,   0,   0, 0, 0, 0, 1, 1, 0);  // hsync continues in vblank
    add(21600,  0,   0,   0, 0, 0, 1, 1, 1, 0);  // v27 h0: pins still v26
    add(21602,  0,   0,   0, 0, 0, 1, 0, 1, 0);  // pins v27 h0: vsync
    add(23201,  0,   0,   0, 0, 0, 1, 0, 1, 0);  // pins v28 h799
    add(23202,  0,   0,   0, 0, 0, 1, 1, 1, 0);  // pins v29 h0
    add(25599,  0,   0,   0, 0, 0, 1, 1, 1, 0);  // v31 h799
    add(25600,  0,   0,   0, 0, 0, 1, 1, 0, 1);  // wrap: frame_start, vblank falls
    add(25601,  0,   0,   0, 0, 0, 1, 1, 0, 0);  // single-cycle pulse
    add(28300, 118,  1,   5, 1, 5, 1, 1, 0, 0);  // frame 2 v3 h300; pins x117

    rst_n = 1'b1;
    cyc = 0;
    foreach (tbl[i]) begin
      e = tbl[i];
      run_to(e.t);
      chk($sformatf("vec%0d_t%0d", i, e.t), obs(), pack(e));
    end

    // ------------------------------------------------ asynchronous mid-line reset
    #1 rst_n = 1'b0;
    #1 chk("async_reset_no_edge", obs(), RESET_VEC);
    repeat (3) @(negedge pix_clk);
    chk("async_reset_held", obs(), RESET_VEC);
    rst_n = 1'b1;
    cyc = 0;
    chk("restart_t0", obs(), RESET_VEC);

    // ------------------------------------------------ one full frame measured
    hs_low = 0; vs_low = 0; vb_hi = 0; fs_cnt = 0;
    hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
    vs_fall = -1; vb_rise = -1; vb_fall = -1; fs_at = -1;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_vb = 1'b0;
    while (cyc < 25602) begin
      step();
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (vblank) vb_hi++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = cyc;
      end
      if (prev_hs && !vga_hs) begin
        if (hs_fall1 < 0) hs_fall1 = cyc;
        else if (hs_fall2 < 0) hs_fall2 = cyc;
      end
      if (!prev_hs && vga_hs && hs_rise1 < 0) hs_rise1 = cyc;
      if (prev_vs && !vga_vs && vs_fall < 0) vs_fall = cyc;
      if (!prev_vb && vblank && vb_rise < 0) vb_rise = cyc;
      if (prev_vb && !vblank && vb_fall < 0) vb_fall = cyc;
      prev_hs = vga_hs;
      prev_vs = vga_vs;
      prev_vb = vblank;
      if (cyc == 66) chk("restart_map_h66", obs(),
                         32'({8'd1, 8'd0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0}));
    end
    chk("hs_first_fall", 32'(hs_fall1), 32'd658);
    chk("hs_width", 32'(hs_rise1 - hs_fall1), 32'd96);
    chk("line_period", 32'(hs_fall2 - hs_fall1), 32'd800);
    chk("hs_low_frame", 32'(hs_low), 32'd3072);
    chk("vs_first_fall", 32'(vs_fall), 32'd21602);
    chk("vs_low_cycles", 32'(vs_low), 32'd1600);
    chk("vblank_rise", 32'(vb_rise), 32'd19200);
    chk("vblank_fall", 32'(vb_fall), 32'd25600);
    chk("vblank_cycles", 32'(vb_hi), 32'd6400);
    chk("frame_start_count", 32'(fs_cnt), 32'd1);
    chk("frame_start_at", 32'(fs_at), 32'd25600);

    // ------------------------------------------------ colour bars (bar 5 at x=160)
    test_mode = 1'b1;
    run_to(25984);  // v0 h384
    chk("bar5_ptr_x", 32'(pix_ptr_x), 32'd160);
    run_to(25986);
`ifdef TEST_PATTERN_EN
    chk("bar5_rgb", 32'({vga_r, vga_g, vga_b}), 32'({3'd7, 3'd0, 3'd7}));
`else
    chk("test_mode_ignored", 32'({vga_r, vga_g, vga_b}), 32'({3'd0, 3'd0, 3'd5}));
`endif
    test_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
